// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The ERROR state exists only when FETCH_MISALIGN_TRAP_EN is defined.
package fetch_unit_pkg;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    StFetch  = 2'b00,
    StHalted = 2'b01,
    StError  = 2'b10
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    StFetch  = 2'b00,
    StHalted = 2'b01
  } fetch_state_e;
`endif

  localparam logic [31:0] InsnNop = 32'h0000_0013;
  localparam logic [31:0] PcStep  = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer: power-of-2 depth synchronous FIFO with flush and
// occupancy count. Head entry is presented combinationally.
module fetch_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [Width-1:0]             push_data,
  input  logic                         pop,
  output logic [Width-1:0]             head,
  output logic                         empty,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             full;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wptr_q] <= push_data;
  end

  // The issue throttle upstream must make this unreachable.
  push_when_full_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, imem req/gnt/rvalid handshake, in-order buffer,
// decode valid/ready. FETCH_MISALIGN_TRAP_EN traps misaligned redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        fetch_err
);

  localparam int unsigned  CntW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW:0] DepthLim = (CntW + 1)'(FIFO_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] discard_q, discard_d;

  logic [63:0]     fifo_head;
  logic            fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            fifo_push;
  logic            ir_pop;
  logic            fire;
  logic            drop;
  logic [CntW:0]   occupancy;
  logic [31:0]     redirect_target;
  logic            redirect_misaligned;

  assign redirect_target = align_word(redirect_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_misaligned = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  // Next state: redirect beats halt; ERROR is left only through reset.
  always_comb begin
    state_d = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (state_q == StError)          state_d = StError;
    else if (redirect_misaligned)    state_d = StError;
    else if (redirect_valid)         state_d = StFetch;
    else if (ir_pop && halt)         state_d = StHalted;
`else
    if (redirect_valid)              state_d = StFetch;
    else if (ir_pop && halt)         state_d = StHalted;
`endif
  end

  // Outputs.
  always_comb begin
    ir_valid  = !fifo_empty && (state_q != StHalted);
    ir_pop    = ir_valid && ir_ready && !redirect_valid;
    // Words granted or buffered after this cycle's pop must fit the buffer.
    occupancy = {1'b0, fifo_count} + {1'b0, outst_q} - {{CntW{1'b0}}, ir_pop};
    imem_req  = rst_n && (state_q == StFetch) && !redirect_valid && (occupancy < DepthLim);
    imem_addr = pc_q;
    ir        = fifo_empty ? InsnNop : fifo_head[31:0];
    ir_pc     = fifo_empty ? 32'h0 : fifo_head[63:32];
`ifdef FETCH_MISALIGN_TRAP_EN
    fetch_err = (state_q == StError);
`else
    fetch_err = 1'b0;
`endif
  end

  // Datapath next state.
  always_comb begin
    fire      = imem_req && imem_gnt;
    drop      = imem_rvalid && (discard_q != '0);
    fifo_push = imem_rvalid && !drop;
    outst_d   = outst_q + CntW'(fire) - CntW'(imem_rvalid);
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    discard_d = discard_q;
    if (redirect_valid) begin
      pc_d      = redirect_target;
      resp_pc_d = redirect_target;
      // Everything still in flight after this edge belongs to the old stream.
      discard_d = outst_d;
    end else begin
      if (fire)      pc_d      = pc_q + PcStep;
      if (fifo_push) resp_pc_d = resp_pc_q + PcStep;
      if (drop)      discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  fetch_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (64)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data ({resp_pc_q, imem_rdata}),
    .pop       (ir_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
